// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with configurable width and depth, an occupancy count,
// almost-full/almost-empty thresholds, error pulses with sticky flags, and a flush.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     clr_err,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     pop_err_on_empty,
  output logic                     push_err_on_full,
  output logic                     udf_sticky,
  output logic                     ovf_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (WIDTH < 1) begin : g_chk_width
    $error("fifo_sync_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("fifo_sync_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             pop_go;
  logic             push_go;
  logic             pop_rej;
  logic             push_rej;
  logic [CW-1:0]    count_nxt;

  // Acceptance uses current-cycle state; flush overrides both directions.
  always_comb begin
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop_ok);
    pop_go    = pop_ok & ~flush;
    push_go   = push_ok & ~flush;
    pop_rej   = pop & ~pop_ok & ~flush;
    push_rej  = push & ~push_ok & ~flush;
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push_ok && !pop_ok)
      count_nxt = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push_go)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      data_out         <= '0;
      empty            <= 1'b1;
      full             <= 1'b0;
      almost_empty     <= 1'b1;
      almost_full      <= 1'b0;
      pop_err_on_empty <= 1'b0;
      push_err_on_full <= 1'b0;
      udf_sticky       <= 1'b0;
      ovf_sticky       <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_go)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop_go) begin
          rd_ptr   <= rd_ptr + AW'(1);
          data_out <= mem[rd_ptr];
        end
      end
      count            <= count_nxt;
      empty            <= (count_nxt == '0);
      full             <= (count_nxt == CW'(DEPTH));
      almost_empty     <= (count_nxt <= CW'(AE_LEVEL));
      almost_full      <= (count_nxt >= CW'(AF_LEVEL));
      pop_err_on_empty <= pop_rej;
      push_err_on_full <= push_rej;
      // A new error in the same cycle as clr_err keeps the flag set.
      if (pop_rej)
        udf_sticky <= 1'b1;
      else if (clr_err)
        udf_sticky <= 1'b0;
      if (push_rej)
        ovf_sticky <= 1'b1;
      else if (clr_err)
        ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst, push, pop, flush, clr_err;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [3:0] count;
  logic       empty, full, almost_empty, almost_full;
  logic       pop_err_on_empty, push_err_on_full, udf_sticky, ovf_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
    .data_in(data_in), .data_out(data_out), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .pop_err_on_empty(pop_err_on_empty), .push_err_on_full(push_err_on_full),
    .udf_sticky(udf_sticky), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 0; pop = 0; flush = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); data_in = 8'h00;
    tick(); tick();
    n_cmp++;
    if ({count, empty, full, almost_empty, almost_full} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b", count, empty, full, almost_empty, almost_full);
    end
    n_cmp++;
    if ({data_out, pop_err_on_empty, push_err_on_full, udf_sticky, ovf_sticky} !== 12'h000) begin
      n_bad++; $display("FAIL reset_data_err: got dout=%h pe=%b ue=%b us=%b os=%b", data_out,
                        pop_err_on_empty, push_err_on_full, udf_sticky, ovf_sticky);
    end
    rst = 0;
    tick();
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 1; i <= 8; i++) begin
      push = 1; data_in = base + 8'(i - 1);
      tick();
      n_cmp++;
      if ({count, almost_empty, almost_full, full, empty} !==
          {4'(i), (i <= 1), (i >= 6), (i == 8), 1'b0}) begin
        n_bad++; $display("FAIL fill_%0d: got cnt=%0d ae=%b af=%b f=%b e=%b", i, count,
                          almost_empty, almost_full, full, empty);
      end
      n_cmp++;
      if ({pop_err_on_empty, push_err_on_full} !== 2'b00) begin
        n_bad++; $display("FAIL fill_err_%0d: got pe=%b ue=%b want 0 0", i, pop_err_on_empty, push_err_on_full);
      end
    end
    push = 0;
  endtask

  task automatic drain(input logic [7:0] exp [8], input string tag);
    for (int i = 0; i < 8; i++) begin
      pop = 1;
      tick();
      n_cmp++;
      if (data_out !== exp[i] || count !== 4'(7 - i)) begin
        n_bad++; $display("FAIL %s_%0d: got dout=%h cnt=%0d want %h %0d", tag, i, data_out, count, exp[i], 7 - i);
      end
    end
    pop = 0;
    tick();
    n_cmp++;
    if (empty !== 1'b1 || pop_err_on_empty !== 1'b0) begin
      n_bad++; $display("FAIL %s_end: got e=%b pe=%b want 1 0", tag, empty, pop_err_on_empty);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [8];
    fill(8'h11);
    push = 1; data_in = 8'h99;
    tick();
    push = 0;
    n_cmp++;
    if ({push_err_on_full, ovf_sticky, count, full} !== {1'b1, 1'b1, 4'd8, 1'b1}) begin
      n_bad++; $display("FAIL ovf_pulse: got pe=%b os=%b cnt=%0d f=%b want 1 1 8 1", push_err_on_full, ovf_sticky, count, full);
    end
    tick();
    n_cmp++;
    if ({push_err_on_full, ovf_sticky} !== 2'b01) begin
      n_bad++; $display("FAIL ovf_one_cycle: got pe=%b os=%b want 0 1", push_err_on_full, ovf_sticky);
    end
    for (int i = 0; i < 8; i++) exp[i] = 8'h11 + 8'(i);
    drain(exp, "ovf_drain");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8];
    fill(8'h11);
    push = 1; pop = 1; data_in = 8'hAA;
    tick();
    push = 0; pop = 0;
    n_cmp++;
    if ({count, data_out, push_err_on_full, pop_err_on_empty} !== {4'd8, 8'h11, 2'b00}) begin
      n_bad++; $display("FAIL full_pushpop: got cnt=%0d dout=%h pe=%b ue=%b want 8 11 0 0", count, data_out,
                        push_err_on_full, pop_err_on_empty);
    end
    for (int i = 0; i < 7; i++) exp[i] = 8'h12 + 8'(i);
    exp[7] = 8'hAA;
    drain(exp, "wrap_drain");
  endtask

  task automatic test_underflow();
    pop = 1;
    tick();
    n_cmp++;
    if ({pop_err_on_empty, udf_sticky, data_out, count} !== {1'b1, 1'b1, 8'hAA, 4'd0}) begin
      n_bad++; $display("FAIL udf_pulse: got pe=%b us=%b dout=%h cnt=%0d want 1 1 aa 0", pop_err_on_empty,
                        udf_sticky, data_out, count);
    end
    clr_err = 1;
    tick();
    n_cmp++;
    if ({pop_err_on_empty, udf_sticky} !== 2'b11) begin
      n_bad++; $display("FAIL udf_set_wins: got pe=%b us=%b want 1 1", pop_err_on_empty, udf_sticky);
    end
    pop = 0;
    tick();
    clr_err = 0;
    n_cmp++;
    if ({pop_err_on_empty, udf_sticky, ovf_sticky} !== 3'b000) begin
      n_bad++; $display("FAIL udf_clear: got pe=%b us=%b os=%b want 0 0 0", pop_err_on_empty, udf_sticky, ovf_sticky);
    end
  endtask

  task automatic test_empty_pushpop();
    push = 1; pop = 1; data_in = 8'h5A;
    tick();
    push = 0; pop = 0;
    n_cmp++;
    if ({pop_err_on_empty, udf_sticky, count, data_out, empty} !== {1'b1, 1'b1, 4'd1, 8'hAA, 1'b0}) begin
      n_bad++; $display("FAIL empty_pushpop: got pe=%b us=%b cnt=%0d dout=%h e=%b want 1 1 1 aa 0",
                        pop_err_on_empty, udf_sticky, count, data_out, empty);
    end
    pop = 1;
    tick();
    pop = 0;
    n_cmp++;
    if ({data_out, count, pop_err_on_empty} !== {8'h5A, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL empty_pushpop_read: got dout=%h cnt=%0d pe=%b want 5a 0 0", data_out, count, pop_err_on_empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      push = 1; data_in = 8'h30 + 8'(i);
      tick();
    end
    n_cmp++;
    if (count !== 4'd5) begin
      n_bad++; $display("FAIL flush_load: got cnt=%0d want 5", count);
    end
    flush = 1; push = 1; pop = 1; data_in = 8'hEE;
    tick();
    idle();
    n_cmp++;
    if ({count, empty, almost_empty, data_out, udf_sticky} !== {4'd0, 1'b1, 1'b1, 8'h5A, 1'b1}) begin
      n_bad++; $display("FAIL flush_state: got cnt=%0d e=%b ae=%b dout=%h us=%b want 0 1 1 5a 1",
                        count, empty, almost_empty, data_out, udf_sticky);
    end
    n_cmp++;
    if ({pop_err_on_empty, push_err_on_full} !== 2'b00) begin
      n_bad++; $display("FAIL flush_err: got pe=%b ue=%b want 0 0", pop_err_on_empty, push_err_on_full);
    end
    push = 1; data_in = 8'h77;
    tick();
    push = 0; pop = 1;
    tick();
    pop = 0;
    n_cmp++;
    if (data_out !== 8'h77 || count !== 4'd0) begin
      n_bad++; $display("FAIL flush_restart: got dout=%h cnt=%0d want 77 0", data_out, count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      push = 1; data_in = 8'hC0 + 8'(i);
      tick();
    end
    push = 1; pop = 1; data_in = 8'hC3;
    #3 rst = 1;
    #1;
    n_cmp++;
    if ({count, empty, full, almost_empty, almost_full, data_out} !== {4'd0, 4'b1010, 8'h00}) begin
      n_bad++; $display("FAIL async_rst_flags: got cnt=%0d e=%b f=%b ae=%b af=%b dout=%h", count, empty, full,
                        almost_empty, almost_full, data_out);
    end
    n_cmp++;
    if ({pop_err_on_empty, push_err_on_full, udf_sticky, ovf_sticky} !== 4'b0000) begin
      n_bad++; $display("FAIL async_rst_err: got pe=%b ue=%b us=%b os=%b", pop_err_on_empty, push_err_on_full,
                        udf_sticky, ovf_sticky);
    end
    idle();
    #2 rst = 0;
    pop = 1;
    tick();
    pop = 0;
    n_cmp++;
    if ({pop_err_on_empty, count, data_out} !== {1'b1, 4'd0, 8'h00}) begin
      n_bad++; $display("FAIL post_rst_pop: got pe=%b cnt=%0d dout=%h want 1 0 00", pop_err_on_empty, count, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_empty_pushpop();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
